// File: rtl/dp_ram_arbiter.sv
// Two-client round-robin arbiter for a 1W/1R dual-port RAM.
// Reads colliding with the granted write address are held off one cycle.
module dp_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [1:0]              wr_req,
  input  logic [2*ADDR_WIDTH-1:0] wr_addr_bus,
  input  logic [2*DATA_WIDTH-1:0] wr_data_bus,
  output logic [1:0]              wr_gnt,
  input  logic [1:0]              rd_req,
  input  logic [2*ADDR_WIDTH-1:0] rd_addr_bus,
  output logic [1:0]              rd_gnt,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
  output logic [DATA_WIDTH-1:0]   ram_data_in,
  output logic                    ram_rd_en,
  output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   ram_data_out
);

  logic wr_ptr_q, wr_ptr_d;
  logic rd_ptr_q, rd_ptr_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_id_q, rsp_id_d;

  logic                  wr_win, rd_win;
  logic                  wr_any, rd_any;
  logic                  raw_hit, rd_go;
  logic [ADDR_WIDTH-1:0] wr_addr_w, rd_addr_w;
  logic [DATA_WIDTH-1:0] wr_data_w;

  // Winner selection: the pointer only matters when both request.
  always_comb begin
    wr_win = wr_req[1];
    if (wr_req == 2'b11)
      wr_win = wr_ptr_q;
    rd_win = rd_req[1];
    if (rd_req == 2'b11)
      rd_win = rd_ptr_q;

    wr_addr_w = wr_win ? wr_addr_bus[2*ADDR_WIDTH-1:ADDR_WIDTH]
                       : wr_addr_bus[ADDR_WIDTH-1:0];
    wr_data_w = wr_win ? wr_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]
                       : wr_data_bus[DATA_WIDTH-1:0];
    rd_addr_w = rd_win ? rd_addr_bus[2*ADDR_WIDTH-1:ADDR_WIDTH]
                       : rd_addr_bus[ADDR_WIDTH-1:0];

    wr_any  = (|wr_req) && !rst_in;
    rd_any  = (|rd_req) && !rst_in;
    raw_hit = wr_any && (rd_addr_w == wr_addr_w);
    rd_go   = rd_any && !raw_hit;
  end

  always_comb begin
    wr_ptr_d    = wr_any ? ~wr_win : wr_ptr_q;
    rd_ptr_d    = rd_go ? ~rd_win : rd_ptr_q;
    rsp_valid_d = rd_go;
    rsp_id_d    = rd_go ? rd_win : rsp_id_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  always_comb begin
    wr_gnt      = 2'b00;
    rd_gnt      = 2'b00;
    ram_wr_en   = wr_any;
    ram_wr_addr = '0;
    ram_data_in = '0;
    ram_rd_en   = rd_go;
    ram_rd_addr = '0;
    if (wr_any) begin
      wr_gnt      = wr_win ? 2'b10 : 2'b01;
      ram_wr_addr = wr_addr_w;
      ram_data_in = wr_data_w;
    end
    if (rd_go) begin
      rd_gnt      = rd_win ? 2'b10 : 2'b01;
      ram_rd_addr = rd_addr_w;
    end
  end

  // A response landing while reset is held is dropped.
  assign rsp_valid = rsp_valid_q && !rst_in;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = ram_data_out;

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Directed bench for dp_ram_arbiter with a behavioural 1-cycle RAM.
module tb_dp_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [1:0]    wr_req, rd_req;
  logic [2*AW-1:0] wr_addr_bus, rd_addr_bus;
  logic [2*DW-1:0] wr_data_bus;
  logic [1:0]    wr_gnt, rd_gnt;
  logic          rsp_valid, rsp_id;
  logic [DW-1:0] rsp_data;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_data_in, ram_data_out;

  logic [DW-1:0] mem [256];

  int vectors = 0;
  int errors  = 0;

  always #5 clk_in = ~clk_in;

  dp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .wr_req(wr_req), .wr_addr_bus(wr_addr_bus),
    .wr_data_bus(wr_data_bus), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr_bus(rd_addr_bus),
    .rd_gnt(rd_gnt), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_data_in(ram_data_in), .ram_rd_en(ram_rd_en),
    .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
  );

  always @(posedge clk_in) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_in = 1'b1;
    wr_req = 2'b11;
    rd_req = 2'b11;
    wr_addr_bus = {8'd2, 8'd1};
    rd_addr_bus = {8'd4, 8'd3};
    wr_data_bus = {32'hBB, 32'hAA};
    ram_data_out = '0;
    tick();
    settle();
    chk("rst_wr_gnt", 64'(wr_gnt), 64'd0);
    chk("rst_rd_gnt", 64'(rd_gnt), 64'd0);
    chk("rst_wr_en", 64'(ram_wr_en), 64'd0);
    chk("rst_rd_en", 64'(ram_rd_en), 64'd0);
    chk("rst_valid0", 64'(rsp_valid), 64'd0);
    chk("rst_waddr", 64'(ram_wr_addr), 64'd0);
    tick();
    settle();
    chk("rst_valid1", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_gnt1", 64'({wr_gnt, rd_gnt}), 64'd0);

    // Round-robin writes; data only advances after a client's grant
    tick();
    rst_in = 1'b0;
    rd_req = 2'b00;
    wr_req = 2'b11;
    wr_addr_bus = {8'd20, 8'd10};
    wr_data_bus = {32'h200, 32'h100};
    settle();
    chk("rr_gnt0", 64'(wr_gnt), 64'b01);
    chk("rr_valid", 64'(rsp_valid), 64'd0);
    tick();
    wr_data_bus = {32'h200, 32'h101};
    settle();
    chk("rr_gnt1", 64'(wr_gnt), 64'b10);
    tick();
    wr_data_bus = {32'h201, 32'h101};
    settle();
    chk("rr_gnt2", 64'(wr_gnt), 64'b01);
    tick();
    wr_data_bus = {32'h201, 32'h102};
    settle();
    chk("rr_gnt3", 64'(wr_gnt), 64'b10);
    chk("rr_wdata3", 64'(ram_data_in), 64'h201);

    // Back-to-back reads of addr 10 and 20 by client 0
    tick();
    wr_req = 2'b00;
    rd_req = 2'b01;
    rd_addr_bus = {8'd0, 8'd10};
    settle();
    chk("rr_rd_gnt10", 64'(rd_gnt), 64'b01);
    tick();
    rd_addr_bus = {8'd0, 8'd20};
    settle();
    chk("rr_rd_gnt20", 64'(rd_gnt), 64'b01);
    chk("rr_rsp10", 64'({rsp_valid, rsp_id, rsp_data}),
        {31'd0, 1'b1, 1'b0, 32'h101});
    tick();
    rd_req = 2'b00;
    settle();
    chk("rr_rsp20", 64'({rsp_valid, rsp_id, rsp_data}),
        {31'd0, 1'b1, 1'b0, 32'h201});

    // Seed addr 5 and 7, then single-client write/read of 47
    tick();
    wr_req = 2'b01;
    wr_addr_bus = {8'd0, 8'd5};
    wr_data_bus = {32'h0, 32'h11};
    settle();
    chk("seed5_gnt", 64'(wr_gnt), 64'b01);
    chk("idle_valid", 64'(rsp_valid), 64'd0);
    tick();
    wr_addr_bus = {8'd0, 8'd7};
    wr_data_bus = {32'h0, 32'd99};
    settle();
    chk("seed7_gnt", 64'(wr_gnt), 64'b01);
    tick();
    wr_addr_bus = {8'd0, 8'd47};
    wr_data_bus = {32'h0, 32'd225};
    settle();
    chk("w47_gnt", 64'(wr_gnt), 64'b01);
    chk("w47_addr", 64'(ram_wr_addr), 64'd47);
    chk("w47_data", 64'(ram_data_in), 64'd225);
    tick();
    wr_req = 2'b00;
    rd_req = 2'b01;
    rd_addr_bus = {8'd0, 8'd47};
    settle();
    chk("r47_gnt", 64'(rd_gnt), 64'b01);
    chk("r47_addr", 64'(ram_rd_addr), 64'd47);
    chk("idle_wr_en", 64'(ram_wr_en), 64'd0);
    tick();
    rd_req = 2'b00;
    settle();
    chk("r47_rsp", 64'({rsp_valid, rsp_id, rsp_data}),
        {31'd0, 1'b1, 1'b0, 32'd225});

    // RAW hazard: client 1 writes 5 while client 0 reads 5
    tick();
    wr_req = 2'b10;
    wr_addr_bus = {8'd5, 8'd0};
    wr_data_bus = {32'hA5, 32'h0};
    rd_req = 2'b01;
    rd_addr_bus = {8'd0, 8'd5};
    settle();
    chk("raw_wr_gnt", 64'(wr_gnt), 64'b10);
    chk("raw_rd_gnt", 64'(rd_gnt), 64'b00);
    chk("raw_rd_en", 64'(ram_rd_en), 64'd0);
    tick();
    wr_req = 2'b00;
    settle();
    chk("raw_retry", 64'(rd_gnt), 64'b01);
    chk("raw_nov", 64'(rsp_valid), 64'd0);
    tick();
    rd_req = 2'b00;
    settle();
    chk("raw_rsp", 64'({rsp_valid, rsp_id, rsp_data}),
        {31'd0, 1'b1, 1'b0, 32'hA5});

    // Parallel ports on different addresses
    tick();
    wr_req = 2'b01;
    wr_addr_bus = {8'd0, 8'd3};
    wr_data_bus = {32'h0, 32'h33};
    rd_req = 2'b10;
    rd_addr_bus = {8'd7, 8'd0};
    settle();
    chk("par_gnts", 64'({wr_gnt, rd_gnt}), 64'b0110);
    tick();
    wr_req = 2'b00;
    rd_req = 2'b00;
    settle();
    chk("par_rsp", 64'({rsp_valid, rsp_id, rsp_data}),
        {31'd0, 1'b1, 1'b1, 32'd99});

    // Reset while a response is due
    tick();
    rd_req = 2'b10;
    rd_addr_bus = {8'd7, 8'd0};
    settle();
    chk("mid_gnt", 64'(rd_gnt), 64'b10);
    tick();
    rst_in = 1'b1;
    rd_req = 2'b00;
    settle();
    chk("mid_drop", 64'(rsp_valid), 64'd0);
    tick();
    rst_in = 1'b0;
    rd_req = 2'b11;
    rd_addr_bus = {8'd20, 8'd10};
    settle();
    chk("post_rst_gnt", 64'(rd_gnt), 64'b01);
    chk("post_rst_v", 64'(rsp_valid), 64'd0);
    tick();
    settle();
    chk("post_rr_gnt", 64'(rd_gnt), 64'b10);
    chk("post_rsp", 64'({rsp_valid, rsp_id, rsp_data}),
        {31'd0, 1'b1, 1'b0, 32'h101});
    tick();
    rd_req = 2'b00;
    settle();
    chk("post_rsp1", 64'({rsp_valid, rsp_id, rsp_data}),
        {31'd0, 1'b1, 1'b1, 32'h201});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
